seg7_stream_display: RTL and testbench
======================================

// Module: seg7_stream_display
// PURPOSE
//   Downstream display stage that drives the 7-segment pins (uo_out[6:0] + dp on uo_out[7]).
//   The game core pushes hex digits over a valid/ready stream into a small FIFO.
//   The block shows each digit for HOLD_CYCLES, then blanks the display for GAP_CYCLES.
//   The gap makes repeated digits (e.g. "3","3") visibly distinct on a single digit.
// PARAMETERS
//   HOLD_CYCLES  1000000  clocks each digit is lit; must be >= 1
//   GAP_CYCLES   100000   clocks blank between digits; 0 = no gap state
//   FIFO_DEPTH   4        entries; power of 2, >= 2
// PORTS
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   ena         in   1  tile enable; low = freeze all state, in_ready forced low
//   in_valid    in   1  producer has a digit
//   in_data     in   5  [3:0] hex nibble, [4] decimal point
//   in_ready    out  1  = ena & !fifo_full (combinational)
//   seg_out     out  7  active-high segments, bit0=a .. bit6=g (registered)
//   dp_out      out  1  decimal point, active-high (registered)
//   busy        out  1  high when state != IDLE or FIFO not empty
//   fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued
// BEHAVIOUR
//   Reset: state=IDLE; FIFO empty; counter=0; seg_out=7'h00; dp_out=0; busy=0; level=0.
//   Push: in_valid & in_ready at a rising edge writes in_data; wr_ptr wraps modulo FIFO_DEPTH.
//   Full FIFO: in_ready=0 even if a pop happens the same cycle (no pass-through).
//   Push and pop in the same cycle (not full): both happen, level unchanged.
//   Decoding is registered at pop time, using the table 0..F:
//     3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//   FSM (advances only when ena=1):
//     IDLE: outputs blank. If FIFO not empty: pop, load seg/dp, cnt=HOLD_CYCLES-1, go SHOW.
//     SHOW: if cnt!=0, cnt-- and hold outputs. If cnt==0:
//       GAP_CYCLES>0: blank outputs, cnt=GAP_CYCLES-1, go GAP.
//       GAP_CYCLES==0 and FIFO not empty: pop, load the next digit, stay SHOW.
//       Otherwise: blank outputs, go IDLE.
//     GAP: if cnt!=0, cnt--. If cnt==0: FIFO not empty -> pop, load, go SHOW; else go IDLE.
//   Latency: handshake at edge N into an empty FIFO in IDLE -> pop at edge N+1.
//     seg_out is valid after edge N+1.
//   Lit time: exactly HOLD_CYCLES clocks. Blank gap: exactly GAP_CYCLES clocks.
//   Counter width: $clog2(max(HOLD,GAP))+1; it never underflows.
//   ena=0 mid-digit: counter, FSM and FIFO freeze; seg_out/dp_out hold their values.
//     Countdown resumes from the same count when ena returns.
//   rst_n asserted mid-operation: immediate blank, FIFO flushed, state IDLE.
//     No queued digit survives the reset.
// TESTING (HOLD_CYCLES=4, GAP_CYCLES=2, FIFO_DEPTH=4)
//   1. Reset: seg_out=00, dp_out=0, in_ready=1 while ena=1, busy=0, fifo_level=0.
//   2. Push 0x05 at edge 0 -> seg_out=6D from edge 1.
//      Lit for 4 clocks, then 00 for 2 clocks, then IDLE with busy=0.
//   3. Push 0x13 -> seg_out=4F, dp_out=1.
//      Then push 0x03,0x03 -> two lit windows of 4F separated by exactly 2 blank clocks.
//   4. With in_valid held high, push 6 digits (0..5) while the first is showing.
//      in_ready drops when level=4. All 6 digits are shown in order; none lost or duplicated.
//   5. Drop ena for 10 clocks during SHOW (cnt=2): outputs hold.
//      After ena rises, exactly 3 more lit clocks follow.
//   6. Assert rst_n low with 3 digits queued mid-SHOW: seg_out=00 immediately, level=0.
//      After release, nothing is displayed.
//   Also re-run scenario 2 with GAP_CYCLES=0: back-to-back digits show with no blank gap.

Source files
------------

// File: rtl/seg7_stream_display.sv
// rtl/seg7_stream_display.sv - streamed hex digits shown one at a time on a 7-segment digit
// Each digit is lit for HOLD_CYCLES, then blanked for GAP_CYCLES so repeats stay distinct.
module seg7_stream_display #(
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 100000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          in_valid,
  input  logic [4:0]                    in_data,
  output logic                          in_ready,
  output logic [6:0]                    seg_out,
  output logic                          dp_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_next_cnt;
  logic [4:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_pop;
  logic            w_blank;
  logic [4:0]      w_head;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == FULL_LEVEL);
  assign in_ready   = ena & ~w_full;
  assign w_push     = in_valid & in_ready;
  assign w_fifo_pop = ena & w_pop;
  assign w_head     = r_mem[r_rd_ptr];

  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign busy       = (r_state != S_IDLE) | ~w_empty;
  assign fifo_level = r_level;

  // Storage is not reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_fifo_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pop        = 1'b0;
    w_blank      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_cnt   = HOLD_LOAD;
          w_next_state = S_SHOW;
        end
      end
      S_SHOW: begin
        if (r_cnt != '0) begin
          w_next_cnt = r_cnt - CW'(1);
        end else if (GAP_CYCLES > 0) begin
          w_blank      = 1'b1;
          w_next_cnt   = GAP_LOAD;
          w_next_state = S_GAP;
        end else if (!w_empty) begin
          w_pop      = 1'b1;
          w_next_cnt = HOLD_LOAD;
        end else begin
          w_blank      = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_next_cnt = r_cnt - CW'(1);
        end else if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_cnt   = HOLD_LOAD;
          w_next_state = S_SHOW;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_blank      = 1'b1;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // With ena low everything freezes, including the displayed segments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_seg   <= 7'h00;
      r_dp    <= 1'b0;
    end else if (ena) begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_pop) begin
        r_seg <= f_decode(w_head[3:0]);
        r_dp  <= w_head[4];
      end else if (w_blank) begin
        r_seg <= 7'h00;
        r_dp  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_stream_display.sv
// tb/tb_seg7_stream_display.sv - bench for seg7_stream_display, gap=2 and gap=0 instances
// Reference: a timeline of display windows; a digit pops at the first enabled edge after its push once the previous lit+gap window has elapsed.
module tb_seg7_stream_display;

  localparam int H = 4;
  localparam int D = 4;
  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_data = 5'h00;
  logic       rdy [2];
  logic [6:0] seg [2];
  logic       dp  [2];
  logic       bsy [2];
  logic [2:0] lvl [2];

  seg7_stream_display #(.HOLD_CYCLES(H), .GAP_CYCLES(2), .FIFO_DEPTH(D)) dut_g (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .seg_out(seg[0]), .dp_out(dp[0]), .busy(bsy[0]), .fifo_level(lvl[0])
  );

  seg7_stream_display #(.HOLD_CYCLES(H), .GAP_CYCLES(0), .FIFO_DEPTH(D)) dut_n (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .seg_out(seg[1]), .dp_out(dp[1]), .busy(bsy[1]), .fifo_level(lvl[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int         gap_of [2] = '{2, 0};
  logic [4:0] qd [2][64];
  int         qh [2];
  int         qt [2];
  longint     last_start [2];
  logic [4:0] cur [2];
  longint     t = 0;
  bit         m_push [2];

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] actual=%0h required=%0h t=%0d @%0t", name, i, act, exp, t, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      qh[i] = 0;
      qt[i] = 0;
      last_start[i] = -1000;
      cur[i] = 5'h00;
    end
  endtask

  function automatic int mlevel(input int i);
    return qt[i] - qh[i];
  endfunction

  task automatic model_edge(input int i);
    if (mlevel(i) > 0 && t >= last_start[i] + H + gap_of[i]) begin
      cur[i] = qd[i][qh[i] % 64];
      qh[i]++;
      last_start[i] = t;
    end
    if (m_push[i]) begin
      qd[i][qt[i] % 64] = in_data;
      qt[i]++;
    end
  endtask

  // One clock: check in_ready mid-cycle, advance the model at the edge, check outputs after it.
  task automatic step();
    bit lit;
    bit exp_rdy;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_rdy = ena && (mlevel(i) < D);
      check("in_ready", i, rdy[i], exp_rdy);
      m_push[i] = in_valid && exp_rdy;
    end
    @(posedge clk);
    if (ena && rst_n) begin
      t++;
      for (int i = 0; i < 2; i++) model_edge(i);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      lit = (t < last_start[i] + H);
      check("seg_out", i, seg[i], lit ? SEG_TAB[cur[i][3:0]] : 7'h00);
      check("dp_out", i, dp[i], lit ? cur[i][4] : 1'b0);
      check("busy", i, bsy[i], (mlevel(i) > 0) || (t < last_start[i] + H + gap_of[i]));
      check("fifo_level", i, lvl[i], mlevel(i));
    end
  endtask

  initial begin
    int k;
    int lit_cnt;
    int shown;
    int nseen;
    logic [6:0] prev;
    logic [6:0] seen [8];
    bit saw_full;

    model_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    #12;
    for (int i = 0; i < 2; i++) begin
      check("rst_seg", i, seg[i], 7'h00);
      check("rst_dp", i, dp[i], 1'b0);
      check("rst_ready", i, rdy[i], 1'b1);
      check("rst_busy", i, bsy[i], 1'b0);
      check("rst_level", i, lvl[i], 3'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step();

    // Single digit 5: four lit clocks, then gap (instance 0) or straight to idle (instance 1)
    in_valid = 1'b1;
    in_data = 5'h05;
    step();
    in_valid = 1'b0;
    for (int s = 0; s < 7; s++) begin
      step();
      check("s2_seg_gap", 0, seg[0], (s < 4) ? 7'h6D : 7'h00);
      check("s2_busy_gap", 0, bsy[0], s < 6);
      check("s2_seg_nogap", 1, seg[1], (s < 4) ? 7'h6D : 7'h00);
      check("s2_busy_nogap", 1, bsy[1], s < 4);
    end

    // Back-to-back digits 1,2: no blank between them without a gap
    in_valid = 1'b1;
    in_data = 5'h01;
    step();
    in_data = 5'h02;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("b2b_seg_nogap", 1, seg[1], 7'h5B);
    check("b2b_seg_gap", 0, seg[0], 7'h00);
    repeat (16) step();

    // 0x13 then two 0x03: decimal point, repeats separated by the gap
    in_valid = 1'b1;
    in_data = 5'h13;
    step();
    in_data = 5'h03;
    step();
    for (int i = 0; i < 2; i++) begin
      check("s3_seg", i, seg[i], 7'h4F);
      check("s3_dp", i, dp[i], 1'b1);
    end
    step();
    in_valid = 1'b0;
    repeat (25) step();

    // Six digits with in_valid held high; record what instance 0 displays
    k = 0;
    nseen = 0;
    saw_full = 1'b0;
    prev = seg[0];
    in_valid = 1'b1;
    in_data = 5'h00;
    for (int s = 0; s < 120; s++) begin
      step();
      if (m_push[0]) k++;
      if (k < 6) in_data = 5'(k);
      else in_valid = 1'b0;
      if (lvl[0] == 3'd4 && rdy[0] == 1'b0) saw_full = 1'b1;
      if (seg[0] != 7'h00 && prev == 7'h00 && nseen < 8) begin
        seen[nseen] = seg[0];
        nseen++;
      end
      prev = seg[0];
    end
    check("s4_pushed", 0, k, 6);
    check("s4_full_seen", 0, saw_full, 1'b1);
    check("s4_shown_count", 0, nseen, 6);
    for (int j = 0; j < 6; j++) begin
      check("s4_order", j, seen[j], SEG_TAB[j]);
    end

    // Freeze mid-digit with ena low
    in_valid = 1'b1;
    in_data = 5'h07;
    step();
    in_valid = 1'b0;
    step();
    step();
    ena = 1'b0;
    repeat (10) step();
    check("s5_hold_seg", 0, seg[0], 7'h07);
    ena = 1'b1;
    lit_cnt = (seg[0] != 7'h00) ? 1 : 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (seg[0] != 7'h00) lit_cnt++;
    end
    check("s5_lit_after_ena", 0, lit_cnt, 3);
    repeat (10) step();

    // Reset with digits queued mid-display
    in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_data = 5'(8 + s);
      step();
    end
    in_valid = 1'b0;
    step();
    check("s6_pre_level", 0, lvl[0], 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("s6_seg", i, seg[i], 7'h00);
      check("s6_level", i, lvl[i], 3'd0);
    end
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    shown = 0;
    for (int s = 0; s < 20; s++) begin
      step();
      if (seg[0] != 7'h00 || seg[1] != 7'h00) shown++;
    end
    check("s6_nothing_shown", 0, shown, 0);

    // Randomized traffic with occasional ena drops
    for (int s = 0; s < 400; s++) begin
      ena = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 2) == 0);
      in_data = 5'($urandom);
      step();
    end
    ena = 1'b1;
    in_valid = 1'b0;
    repeat (60) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
